// File: rtl/ram_cmd_arbiter_if.sv
// Requester, RAM command and lock-status bundle for ram_cmd_arbiter.
// The slave modport is the arbiter's view of the bus.
interface ram_cmd_arbiter_if #(
   parameter int ADDR_SIZE = 8
);
   logic                 req_valid_0;
   logic                 req_valid_1;
   logic [ADDR_SIZE+1:0] req_din_0;
   logic [ADDR_SIZE+1:0] req_din_1;
   logic                 req_ready_0;
   logic                 req_ready_1;
   logic                 rsp_valid_0;
   logic                 rsp_valid_1;
   logic [ADDR_SIZE-1:0] rsp_data;
   logic                 ram_rx_valid;
   logic [ADDR_SIZE+1:0] ram_din;
   logic                 ram_tx_valid;
   logic [ADDR_SIZE-1:0] ram_dout;
   logic                 locked;
   logic                 lock_owner;
   logic                 lock_timeout;

   modport master (
      output req_valid_0,
      output req_valid_1,
      output req_din_0,
      output req_din_1,
      output ram_tx_valid,
      output ram_dout,
      input  req_ready_0,
      input  req_ready_1,
      input  rsp_valid_0,
      input  rsp_valid_1,
      input  rsp_data,
      input  ram_rx_valid,
      input  ram_din,
      input  locked,
      input  lock_owner,
      input  lock_timeout
   );

   modport slave (
      input  req_valid_0,
      input  req_valid_1,
      input  req_din_0,
      input  req_din_1,
      input  ram_tx_valid,
      input  ram_dout,
      output req_ready_0,
      output req_ready_1,
      output rsp_valid_0,
      output rsp_valid_1,
      output rsp_data,
      output ram_rx_valid,
      output ram_din,
      output locked,
      output lock_owner,
      output lock_timeout
   );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// Two-requester arbiter for a single-port RAM command port with
// address-to-data locking, read-response routing and lock timeout.
module ram_cmd_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 15
) (
   input logic              clk,
   input logic              rst_n,
   ram_cmd_arbiter_if.slave bus
);
   localparam int        W   = ADDR_SIZE + 2;
   localparam logic [7:0] TMO = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      LOCKED,
      RD_WAIT
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_ptr;
   logic                 w_ptr_nxt;
   logic                 r_owner;
   logic                 w_owner_nxt;
   logic [7:0]           r_cnt;
   logic [7:0]           w_cnt_nxt;
   logic [7:0]           w_cnt_inc;
   logic                 r_ram_rx_valid;
   logic [W-1:0]         r_ram_din;
   logic                 r_rsp_valid_0;
   logic                 r_rsp_valid_1;
   logic [ADDR_SIZE-1:0] r_rsp_data;
   logic                 r_lock_timeout;

   logic                 w_rdy_0;
   logic                 w_rdy_1;
   logic                 w_gnt_0;
   logic                 w_gnt_1;
   logic                 w_acc_0;
   logic                 w_acc_1;
   logic                 w_acc;
   logic                 w_src;
   logic [W-1:0]         w_word;
   logic [1:0]           w_cmd;
   logic                 w_tmo;
   logic                 w_capture;

   always_comb begin
      w_rdy_0 = 1'b0;
      w_rdy_1 = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_rdy_0 = !bus.req_valid_1 || !r_ptr;
            w_rdy_1 = !bus.req_valid_0 || r_ptr;
         end
         LOCKED: begin
            w_rdy_0 = !r_owner;
            w_rdy_1 = r_owner;
         end
         default: begin
            w_rdy_0 = 1'b0;
            w_rdy_1 = 1'b0;
         end
      endcase
   end

   // Ready is forced low while reset is asserted.
   assign w_gnt_0 = rst_n & w_rdy_0;
   assign w_gnt_1 = rst_n & w_rdy_1;
   assign w_acc_0 = bus.req_valid_0 & w_gnt_0;
   assign w_acc_1 = bus.req_valid_1 & w_gnt_1;
   assign w_acc   = w_acc_0 | w_acc_1;
   assign w_src   = w_acc_1;
   assign w_word  = w_acc_1 ? bus.req_din_1 : bus.req_din_0;
   assign w_cmd   = w_word[W-1:W-2];
   assign w_cnt_inc = r_cnt + 8'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_tmo       = 1'b0;
      w_capture   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_acc) begin
               w_owner_nxt = w_src;
               w_cnt_nxt   = 8'd0;
               unique case (w_cmd)
                  2'b01:   w_ptr_nxt   = ~w_src;
                  2'b11:   w_state_nxt = RD_WAIT;
                  default: w_state_nxt = LOCKED;
               endcase
            end
         end
         LOCKED: begin
            if (w_acc) begin
               w_cnt_nxt = 8'd0;
               unique case (w_cmd)
                  2'b01: begin
                     w_state_nxt = IDLE;
                     w_ptr_nxt   = ~r_owner;
                  end
                  2'b11:   w_state_nxt = RD_WAIT;
                  default: w_state_nxt = LOCKED;
               endcase
            end else if (w_cnt_inc == TMO) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = ~r_owner;
               w_cnt_nxt   = 8'd0;
               w_tmo       = 1'b1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         RD_WAIT: begin
            // While the read strobe is still out, tx_valid is stale.
            if (!r_ram_rx_valid && bus.ram_tx_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = IDLE;
               w_ptr_nxt   = ~r_owner;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_ptr          <= 1'b0;
         r_owner        <= 1'b0;
         r_cnt          <= 8'd0;
         r_ram_rx_valid <= 1'b0;
         r_ram_din      <= '0;
         r_rsp_valid_0  <= 1'b0;
         r_rsp_valid_1  <= 1'b0;
         r_rsp_data     <= '0;
         r_lock_timeout <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_ptr          <= w_ptr_nxt;
         r_owner        <= w_owner_nxt;
         r_cnt          <= w_cnt_nxt;
         r_ram_rx_valid <= w_acc;
         if (w_acc)
            r_ram_din <= w_word;
         r_rsp_valid_0  <= w_capture & ~r_owner;
         r_rsp_valid_1  <= w_capture & r_owner;
         if (w_capture)
            r_rsp_data <= bus.ram_dout;
         r_lock_timeout <= w_tmo;
      end
   end

   assign bus.req_ready_0  = w_gnt_0;
   assign bus.req_ready_1  = w_gnt_1;
   assign bus.ram_rx_valid = r_ram_rx_valid;
   assign bus.ram_din      = r_ram_din;
   assign bus.rsp_valid_0  = r_rsp_valid_0;
   assign bus.rsp_valid_1  = r_rsp_valid_1;
   assign bus.rsp_data     = r_rsp_data;
   assign bus.locked       = (r_state != IDLE);
   assign bus.lock_owner   = r_owner;
   assign bus.lock_timeout = r_lock_timeout;
endmodule
